// File: rtl/logic_exec_pkg.sv
// Package: logic_exec_pkg
// Typed view of the shared operation encodings plus the default width.
// The raw values come from alu_defs.vh so every user agrees on them.
`include "alu_defs.vh"

package logic_exec_pkg;

  localparam int WIDTH_DEFAULT = `ALU_WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    OP_LOAD = `ALU_OP_LOAD,
    OP_AND  = `ALU_OP_AND,
    OP_OR   = `ALU_OP_OR,
    OP_XOR  = `ALU_OP_XOR
  } op_e;

endpackage

// File: rtl/alu_defs.vh
// Shared operation encodings and default datapath width for logic_exec,
// unit_L and the testbench. Guarded so it can be pulled in from several
// compilation units.
`ifndef ALU_DEFS_VH
`define ALU_DEFS_VH

`define ALU_OP_LOAD      2'b00
`define ALU_OP_AND       2'b01
`define ALU_OP_OR        2'b10
`define ALU_OP_XOR       2'b11

`define ALU_WIDTH_DEFAULT 32

`endif

// File: rtl/logic_exec_unit_l.sv
// Module: unit_L
// Purely combinational bitwise logic unit.
// Ports:
//   a  in  WIDTH  operand A
//   b  in  WIDTH  operand B
//   s  in  2      operation select (AND / OR / XOR)
//   y  out WIDTH  result
// The LOAD encoding is never routed here by logic_exec; it yields zero.
`include "alu_defs.vh"

module unit_L
  import logic_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (s)
      `ALU_OP_AND: y = a & b;
      `ALU_OP_OR:  y = a | b;
      `ALU_OP_XOR: y = a ^ b;
      default:     y = '0;
    endcase
  end

endmodule

// File: rtl/logic_exec.sv
// Module: logic_exec
// Command FIFO feeding a single-register bitwise execute stage with an
// accumulator that can replace operand A.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   command handshake
//   in_a, in_b          operands
//   in_op               00 LOAD, 01 AND, 10 OR, 11 XOR
//   in_acc              take operand A from the accumulator
//   out_valid/out_ready result handshake
//   out_res             result register
//   count               FIFO occupancy, 0..DEPTH
//   out_zero            result-is-zero flag (only with LOGIC_EXEC_FLAGS_EN)
// Optional feature macro: LOGIC_EXEC_FLAGS_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on count and rst (never on out_ready), so a
// full FIFO refuses a push even on an edge where it also pops. out_res and
// out_valid hold while out_valid=1 and out_ready=0.
`include "alu_defs.vh"

module logic_exec
  import logic_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [1:0]               in_op,
  input  logic                     in_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_res,
`ifdef LOGIC_EXEC_FLAGS_EN
  output logic                     out_zero,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // FIFO storage, one field per array
  logic [WIDTH-1:0] a_mem   [DEPTH];
  logic [WIDTH-1:0] b_mem   [DEPTH];
  logic [1:0]       op_mem  [DEPTH];
  logic             acc_mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic [WIDTH-1:0] acc;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [1:0]       head_op;
  logic             head_acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] unit_y;
  logic [WIDTH-1:0] result;

  assign count    = occ;
  assign in_ready = (occ != FULL) && !rst;
  assign push     = in_valid && in_ready;
  // Pop uses the registered occupancy, so a push into an empty FIFO is
  // only visible to the execute stage on the following edge.
  assign pop      = (occ != '0) && (!out_valid || out_ready);

  assign head_a   = a_mem[rd_ptr];
  assign head_b   = b_mem[rd_ptr];
  assign head_op  = op_mem[rd_ptr];
  assign head_acc = acc_mem[rd_ptr];
  assign op_a     = head_acc ? acc : head_a;

  unit_L #(.WIDTH(WIDTH)) u_unit_l (
    .a (op_a),
    .b (head_b),
    .s (head_op),
    .y (unit_y)
  );

  // LOAD bypasses the logic unit and passes operand B straight through.
  always_comb begin
    result = unit_y;
    if (head_op == `ALU_OP_LOAD) result = head_b;
  end

  // Storage has no reset: contents are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]   <= in_a;
      b_mem[wr_ptr]   <= in_b;
      op_mem[wr_ptr]  <= in_op;
      acc_mem[wr_ptr] <= in_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      acc       <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_res   <= result;
      acc       <= result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LOGIC_EXEC_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_zero <= 1'b0;
    end else if (pop) begin
      out_zero <= (result == '0);
    end
  end
`endif

endmodule

// File: tb/tb_logic_exec.sv
// Directed testbench for logic_exec: reset, single command, back-to-back
// ops, backpressure/capacity, accumulator chain, mid-operation reset and
// (when LOGIC_EXEC_FLAGS_EN is defined) the zero flag.
`include "alu_defs.vh"

module tb_logic_exec;
  import logic_exec_pkg::*;

  localparam int W = WIDTH_DEFAULT;
  localparam int D = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [W-1:0]         in_a = '0;
  logic [W-1:0]         in_b = '0;
  logic [1:0]           in_op = 2'b00;
  logic                 in_acc = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [W-1:0]         out_res;
  logic [$clog2(D):0]   count;
`ifdef LOGIC_EXEC_FLAGS_EN
  logic                 out_zero;
`endif

  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  logic_exec #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
`ifdef LOGIC_EXEC_FLAGS_EN
    .out_zero  (out_zero),
`endif
    .count     (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one command and hold it until accepted (bounded).
  task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic use_acc);
    bit done = 0;
    in_a = a; in_b = b; in_op = op; in_acc = use_acc; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      bad++;
      $display("FAIL push_timeout: in_ready stayed 0, required 1");
    end
  endtask

  // Wait (bounded) for out_valid and return out_res.
  task automatic wait_result(output logic [W-1:0] res);
    bit done = 0;
    res = 'x;
    for (int i = 0; i < 10 && !done; i++) begin
      if (out_valid) begin
        res = out_res;
        done = 1;
      end else begin
        step();
      end
    end
    if (!done) begin
      bad++;
      $display("FAIL result_timeout: out_valid stayed 0, required 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready_low: got %b need 0", in_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready_high: got %b need 1", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b need 0", out_valid);
    end
    total++;
    if (count !== '0) begin
      bad++; $display("FAIL reset_count: got %0d need 0", count);
    end
    total++;
    if (out_res !== '0) begin
      bad++; $display("FAIL reset_out_res: got %h need 0", out_res);
    end
  endtask

  task automatic test_single_and();
    out_ready = 1'b1;
    in_a = 32'hDC754CD2; in_b = 32'h4124F055; in_op = `ALU_OP_AND;
    in_acc = 1'b0; in_valid = 1'b1;
    step();                      // accepted at this edge
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || count !== 1) begin
      bad++; $display("FAIL single_accept_edge: valid=%b count=%0d need 0/1", out_valid, count);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_res !== 32'h40244050) begin
      bad++; $display("FAIL single_and: valid=%b res=%h need 1/40244050", out_valid, out_res);
    end
    total++;
    if (count !== 0) begin
      bad++; $display("FAIL single_count_after_pop: got %0d need 0", count);
    end
    step();                      // consumed, FIFO empty -> valid clears
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_valid_clear: got %b need 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   ops [3];
    logic [W-1:0] exp [3];
    ops[0] = `ALU_OP_AND; ops[1] = `ALU_OP_OR; ops[2] = `ALU_OP_XOR;
    exp[0] = 32'h40244050; exp[1] = 32'hDD75FCD7; exp[2] = 32'h9D51BC87;
    out_ready = 1'b1;
    in_a = 32'hDC754CD2; in_b = 32'h4124F055; in_acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        in_valid = 1'b1; in_op = ops[i];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 3) begin
        total++;
        if (out_valid !== 1'b1 || out_res !== exp[i-1]) begin
          bad++;
          $display("FAIL b2b_result%0d: valid=%b res=%h need 1/%h", i-1, out_valid, out_res, exp[i-1]);
        end
      end
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drained: valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int got = 0;
    logic [W-1:0] obs;
    out_ready = 1'b0;
    exp_q.delete();
    in_a = '0; in_op = `ALU_OP_LOAD; in_acc = 1'b0;
    // offer up to 6 distinct commands for 8 cycles
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = (accepted < 6);
      in_b = 32'hA000_0000 + W'(accepted);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_b);
        accepted++;
        step();
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    total++;
    if (accepted !== 5) begin
      bad++; $display("FAIL capacity_accepted: got %0d need 5", accepted);
    end
    total++;
    if (in_ready !== 1'b0 || count !== D) begin
      bad++; $display("FAIL capacity_full: in_ready=%b count=%0d need 0/%0d", in_ready, count, D);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL full_no_ready_while_pop: got %b need 0", in_ready);
    end
    for (int cyc = 0; cyc < 12 && exp_q.size() > 0; cyc++) begin
      if (out_valid && out_ready) begin
        obs = out_res;
        total++;
        if (obs !== exp_q[0]) begin
          bad++; $display("FAIL drain_order%0d: got %h need %h", got, obs, exp_q[0]);
        end
        void'(exp_q.pop_front());
        got++;
      end
      step();
    end
    total++;
    if (got !== 5) begin
      bad++; $display("FAIL drain_count: got %0d need 5", got);
    end
    total++;
    if (out_valid !== 1'b0 || count !== 0) begin
      bad++; $display("FAIL drain_empty: valid=%b count=%0d need 0/0", out_valid, count);
    end
  endtask

  task automatic test_accumulator();
    logic [W-1:0] r;
    out_ready = 1'b1;
    push_one(32'h12345678, 32'hFFFF0000, `ALU_OP_LOAD, 1'b0);
    wait_result(r);
    total++;
    if (r !== 32'hFFFF0000) begin
      bad++; $display("FAIL acc_load: got %h need FFFF0000", r);
    end
    push_one(32'hFFFFFFFF, 32'h0F0F0F0F, `ALU_OP_AND, 1'b1);
    wait_result(r);
    total++;
    if (r !== 32'h0F0F0000) begin
      bad++; $display("FAIL acc_and: got %h need 0F0F0000", r);
    end
    push_one(32'h00000000, 32'hFFFFFFFF, `ALU_OP_XOR, 1'b1);
    wait_result(r);
    total++;
    if (r !== 32'hF0F0FFFF) begin
      bad++; $display("FAIL acc_xor: got %h need F0F0FFFF", r);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] r;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one('0, 32'h5555_0000 + W'(i), `ALU_OP_LOAD, 1'b0);
    total++;
    if (count !== 3 || out_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_setup: count=%0d valid=%b need 3/1", count, out_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++;
    if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_res !== '0) begin
      bad++;
      $display("FAIL midrst_cleared: count=%0d valid=%b ready=%b res=%h need 0/0/1/0",
               count, out_valid, in_ready, out_res);
    end
    // acc AND all-ones exposes the accumulator: zero only if it was cleared
    out_ready = 1'b1;
    push_one(32'hFFFFFFFF, 32'hFFFFFFFF, `ALU_OP_AND, 1'b1);
    wait_result(r);
    total++;
    if (r !== '0) begin
      bad++; $display("FAIL midrst_acc: got %h need 00000000", r);
    end
    step();
  endtask

`ifdef LOGIC_EXEC_FLAGS_EN
  task automatic test_flags();
    logic [W-1:0] r;
    out_ready = 1'b1;
    push_one(32'h12345678, 32'h12345678, `ALU_OP_XOR, 1'b0);
    wait_result(r);
    total++;
    if (r !== '0 || out_zero !== 1'b1) begin
      bad++; $display("FAIL flag_zero: res=%h zero=%b need 0/1", r, out_zero);
    end
    push_one(32'h12345678, 32'h12345678, `ALU_OP_OR, 1'b0);
    wait_result(r);
    total++;
    if (r !== 32'h12345678 || out_zero !== 1'b0) begin
      bad++; $display("FAIL flag_nonzero: res=%h zero=%b need 12345678/0", r, out_zero);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_and();
    test_back_to_back();
    test_backpressure();
    test_accumulator();
    test_reset_mid_op();
`ifdef LOGIC_EXEC_FLAGS_EN
    test_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
